// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch queue.
package fetch_queue_pkg;

  // Default queue depth and datapath width.
  localparam int FQ_DEPTH   = 4;
  localparam int WORD_WIDTH = 32;

  // Instruction word shown to decode when the queue holds nothing.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Occupancy update selector, indexed as {push, pop}.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are never cleared; only the pointers
// in the parent decide which entries are live.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = 2 * WORD_WIDTH,
  parameter int ADDR_W = $clog2(FQ_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Capture the incoming entry at the write address when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end else begin
      r_mem[waddr] <= r_mem[waddr];
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue. Holds {pc, instr} pairs in program
// order, presents the head show-ahead to decode, backpressures fetch when
// full and empties in one cycle on a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           pc_in,
  input  logic [WIDTH-1:0]           instr_in,
  input  logic                       stallD,
  input  logic                       flush,
  output logic                       stallF,
  output logic                       validD,
  output logic [WIDTH-1:0]           pcD,
  output logic [WIDTH-1:0]           instrD,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  cnt_op_e            w_cnt_op;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [2*WIDTH-1:0] w_rdata;

  // Status flags come from the registered count only, so stallF has no
  // combinational path from stallD or valid_in.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});

  // Flush overrides both sides; a full queue refuses pushes even while it
  // pops, the freed slot becoming usable the following cycle.
  assign w_push = valid_in & ~w_full & ~flush;
  assign w_pop  = ~w_empty & ~stallD & ~flush;

  fetch_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * WIDTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_tail),
    .wdata ({pc_in, instr_in}),
    .raddr (r_head),
    .rdata (w_rdata)
  );

  // Next occupancy: count + push - pop.
  always_comb begin
    w_cnt_op    = cnt_op_e'({w_push, w_pop});
    w_count_nxt = r_count;
    case (w_cnt_op)
      CNT_INC:  w_count_nxt = r_count + CNT_W'(1);
      CNT_DEC:  w_count_nxt = r_count - CNT_W'(1);
      CNT_BOTH: w_count_nxt = r_count;
      CNT_HOLD: w_count_nxt = r_count;
      default:  w_count_nxt = r_count;
    endcase
  end

  // Pointer and occupancy registers; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_head  <= w_pop  ? (r_head + PTR_W'(1)) : r_head;
      r_tail  <= w_push ? (r_tail + PTR_W'(1)) : r_tail;
      r_count <= w_count_nxt;
    end
  end

  // Show-ahead head presentation; an empty queue shows a bubble.
  always_comb begin
    pcD    = {WIDTH{1'b0}};
    instrD = WIDTH'(NOP_INSTR);
    if (!w_empty) begin
      pcD    = w_rdata[2*WIDTH-1:WIDTH];
      instrD = w_rdata[WIDTH-1:0];
    end else begin
      pcD    = {WIDTH{1'b0}};
      instrD = WIDTH'(NOP_INSTR);
    end
  end

  assign validD = ~w_empty;
  assign stallF = w_full;
  assign count  = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue plus a hand-written
// wrap-around sequence.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        stallD;
  logic        flush;
  logic        stallF;
  logic        validD;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .pc_in    (pc_in),
    .instr_in (instr_in),
    .stallD   (stallD),
    .flush    (flush),
    .stallF   (stallF),
    .validD   (validD),
    .pcD      (pcD),
    .instrD   (instrD),
    .count    (count)
  );

  typedef struct packed {
    logic        rst;
    logic        vin;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [2:0]  ecnt;
    logic        esf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [31:0] pc,
                     input logic [31:0] ins, input logic st, input logic fl,
                     input logic ev, input logic [31:0] epc,
                     input logic [31:0] eins, input logic [2:0] ecnt,
                     input logic esf);
    vec_t x;
    x.rst = r; x.vin = v; x.pc = pc; x.instr = ins; x.stall = st;
    x.flush = fl; x.ev = ev; x.epc = epc; x.einstr = eins; x.ecnt = ecnt;
    x.esf = esf;
    tbl.push_back(x);
  endtask

  // Drive inputs away from the active edge, then step past it.
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic st, input logic fl);
    @(negedge clk);
    rst = r; valid_in = v; pc_in = pc; instr_in = ins; stallD = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eins, input logic [2:0] ecnt,
                       input logic esf);
    n_vec++;
    if (validD !== ev || pcD !== epc || instrD !== eins || count !== ecnt ||
        stallF !== esf) begin
      n_err++;
      $display("FAIL %s: got v=%0b pc=%h instr=%h cnt=%0d sF=%0b, want v=%0b pc=%h instr=%h cnt=%0d sF=%0b",
               tag, validD, pcD, instrD, count, stallF, ev, epc, eins, ecnt, esf);
    end
  endtask

  initial begin
    int exp_pc;
    int pushed;
    rst = 1'b1; valid_in = 1'b0; pc_in = 32'h0; instr_in = 32'h0;
    stallD = 1'b0; flush = 1'b0;

    //   rst   vin   pc            instr         stD   fl    ev    epc           einstr        cnt   sF
    // Reset and pass-through streaming
    add(1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        3'd0, 1'b0);
    add(1'b0, 1'b1, 32'h00400000, 32'h20080005, 1'b0, 1'b0, 1'b1, 32'h00400000, 32'h20080005, 3'd1, 1'b0);
    add(1'b0, 1'b1, 32'h00400004, 32'h20080006, 1'b0, 1'b0, 1'b1, 32'h00400004, 32'h20080006, 3'd1, 1'b0);
    add(1'b0, 1'b1, 32'h00400008, 32'h20080007, 1'b0, 1'b0, 1'b1, 32'h00400008, 32'h20080007, 3'd1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        3'd0, 1'b0);
    // Empty bubble
    add(1'b0, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        3'd0, 1'b0);
    // Fill to full under decode stall
    add(1'b0, 1'b1, 32'h0,        32'h10000000, 1'b1, 1'b0, 1'b1, 32'h0,        32'h10000000, 3'd1, 1'b0);
    add(1'b0, 1'b1, 32'h4,        32'h10000004, 1'b1, 1'b0, 1'b1, 32'h0,        32'h10000000, 3'd2, 1'b0);
    add(1'b0, 1'b1, 32'h8,        32'h10000008, 1'b1, 1'b0, 1'b1, 32'h0,        32'h10000000, 3'd3, 1'b0);
    add(1'b0, 1'b1, 32'hC,        32'h1000000C, 1'b1, 1'b0, 1'b1, 32'h0,        32'h10000000, 3'd4, 1'b1);
    add(1'b0, 1'b1, 32'h10,       32'h10000010, 1'b1, 1'b0, 1'b1, 32'h0,        32'h10000000, 3'd4, 1'b1);
    // Pop while full: push stays suppressed, stallF drops
    add(1'b0, 1'b1, 32'h10,       32'h10000010, 1'b0, 1'b0, 1'b1, 32'h4,        32'h10000004, 3'd3, 1'b0);
    add(1'b0, 1'b1, 32'h10,       32'h10000010, 1'b1, 1'b0, 1'b1, 32'h4,        32'h10000004, 3'd4, 1'b1);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h8,        32'h10000008, 3'd3, 1'b0);
    // Flush with concurrent push
    add(1'b0, 1'b1, 32'h100,      32'h11111111, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 1'b0);
    add(1'b0, 1'b1, 32'h200,      32'h22222222, 1'b1, 1'b0, 1'b1, 32'h200,      32'h22222222, 3'd1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        3'd0, 1'b0);
    // Reset mid-stream with valid_in
    add(1'b0, 1'b1, 32'h300,      32'h33333300, 1'b1, 1'b0, 1'b1, 32'h300,      32'h33333300, 3'd1, 1'b0);
    add(1'b0, 1'b1, 32'h304,      32'h33333304, 1'b1, 1'b0, 1'b1, 32'h300,      32'h33333300, 3'd2, 1'b0);
    add(1'b1, 1'b1, 32'h308,      32'h33333308, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        3'd0, 1'b0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        3'd0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].vin, tbl[i].pc, tbl[i].instr, tbl[i].stall,
           tbl[i].flush);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].einstr,
            tbl[i].ecnt, tbl[i].esf);
    end

    // Wrap-around: bursts of 3 pushes then 3 pops, 12 instructions total.
    exp_pc = 0;
    pushed = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b1, 32'(pushed * 4), 32'hC000_0000 | 32'(pushed * 4),
             1'b1, 1'b0);
        pushed++;
        n_vec++;
        if (count > 3'd4 || count !== 3'(k + 1)) begin
          n_err++;
          $display("FAIL wrap_cnt b%0d k%0d: got cnt=%0d, want %0d", b, k,
                   count, k + 1);
        end
      end
      for (int k = 0; k < 3; k++) begin
        check($sformatf("wrap_head b%0d k%0d", b, k), 1'b1, 32'(exp_pc),
              32'hC000_0000 | 32'(exp_pc), 3'(3 - k), 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_pc += 4;
      end
      check($sformatf("wrap_empty b%0d", b), 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage.
- Captures the {pc, instr} pair from fetch each cycle fetch is not stalled, and presents entries to decode in program order.
- Backpressures fetch via stallF when full; emptied in one cycle by a control-flow redirect (flush).
- Absorbs short decode stalls without freezing the PC.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
WIDTH, 32, PC and instruction width (matches `WORD_WIDTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  fetch presents a valid {pc_in, instr_in} this cycle
pc_in  input  WIDTH  PC of fetched instruction
instr_in  input  WIDTH  fetched instruction word
stallD  input  1  decode cannot consume this cycle
flush  input  1  redirect; discard all queued and incoming entries
stallF  output  1  hold PC; queue cannot accept
validD  output  1  head entry valid for decode
pcD  output  WIDTH  PC of head entry
instrD  output  WIDTH  instruction of head entry
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rst sampled high at a rising edge. Pointers are cleared and count=0, giving validD=0, stallF=0, pcD=0, instrD=0.
- Reset mid-operation discards all contents, identical to flush.
- Storage: DEPTH x {pc, instr} register array, with head and tail pointers of $clog2(DEPTH) bits and a separate count register.
- Pointers wrap modulo DEPTH; full is count==DEPTH and empty is count==0.
- Head outputs are show-ahead:
  - validD = (count != 0).
  - pcD and instrD come from entry[head] when valid.
  - When empty, pcD=0 and instrD=`NOP_INSTR (32'h0000_0000), so decode sees a bubble.
- stallF = full. It is derived from registered count only, with no combinational path from stallD or valid_in.
- push = valid_in & ~full & ~flush. It writes entry[tail] and increments tail.
- pop = validD & ~stallD & ~flush. It increments head.
- count update: next = count + push - pop.
  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
  - When full, push is suppressed even if a pop occurs. The freed slot is usable the next cycle, when stallF deasserts.
- Latency: an entry pushed at edge N is visible on pcD/instrD/validD after edge N. It is one cycle from fetch to decode, with no bypass.
- flush takes priority over push and pop. At the edge: head=tail=0 and count=0; the concurrent valid_in entry is dropped. The queue is empty in the next cycle.
- Once full, the queue accepts nothing until a pop occurs.
- valid_in while full is ignored. Fetch must hold its PC, which it does because stallF=1, and re-present the pair.
- Storage contents are not cleared on reset or flush; only the pointers and count are.

Decomposition:
- defines.vh gains:
  - `FQ_DEPTH (default 4)
  - `NOP_INSTR (32'h0000_0000)
  - `WORD_WIDTH reused for pc and instr
- Optional sub-module fetch_queue_mem: DEPTH x 2*WIDTH register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count and flush logic stay in fetch_queue.

Test Plan:
1. Pass-through:
   - Stimulus: rst 1 cycle, then valid_in=1 with pc_in=0x00400000, instr_in=0x20080005, stallD=0.
   - Required: next cycle validD=1, pcD=0x00400000, instrD=0x20080005; count stays 1 under steady streaming (push and pop each cycle).
2. Fill to full:
   - Stimulus: stallD=1, 5 pushes with pc 0x0, 0x4, 0x8, 0xC, 0x10.
   - Required: after 4 edges count=4 and stallF=1; the 5th is not stored. Releasing stallD for 1 cycle pops pc 0x0, and next cycle stallF=0.
3. Wrap-around:
   - Stimulus: alternate bursts of 3 pushes and 3 pops for 12 instructions, pc 0x0..0x2C.
   - Required: decode sees all 12 in order and count never exceeds 4.
4. Flush with concurrent push:
   - Stimulus: count=3, flush=1 and valid_in=1 with pc_in=0x100 in the same cycle.
   - Required: next cycle count=0, validD=0, instrD=0, and 0x100 is absent. A following push of 0x200 appears alone.
5. Empty bubble: with no valid_in, validD=0, pcD=0, instrD=0, stallF=0.
6. Reset mid-stream:
   - Stimulus: count=2, assert rst at an edge with valid_in=1.
   - Required: the next cycle has count=0, validD=0, stallF=0, and the entry is not captured.
